ipg_tx: RTL and testbench
=========================

# ipg_tx

Transmit-side IPG inserter. It sits between the 64b/66b PCS encoder output and the TX gearbox. It opportunistically replaces all-idle control blocks with IPG request blocks (type 0x1a) or IPG response blocks (type 0x1f) that carry 56-bit shim-layer payloads. These are the blocks the link partner's IPG receive stage decodes and restores to idle. All other blocks pass through unchanged with a fixed one-cycle latency.

## Interface
Parameters:
- REQ_FIFO_DEPTH, 8, request FIFO entries; power of two, ≥2
- REQ_FIFO_AW, $clog2(REQ_FIFO_DEPTH), derived; do not override

Ports:
- clk  input  1  line clock, one encoded block per cycle
- rst  input  1  synchronous, active-high reset
- encoded_tx_data_in  input  64  block payload from encoder, bits [7:0] = block type
- encoded_tx_hdr_in  input  2  sync header (2'b10 data, 2'b01 control)
- req_data  input  56  IPG request payload
- req_valid  input  1  request offered
- req_ready  output  1  request FIFO not full
- resp_data  input  56  IPG response payload
- resp_valid  input  1  response offered
- resp_ready  output  1  response holding register empty
- encoded_tx_data_out  output  64  block to gearbox
- encoded_tx_hdr_out  output  2  sync header to gearbox
- ipg_inserted  output  1  one-cycle pulse: the current output block is an inserted REQ/RESP
- req_fifo_level  output  REQ_FIFO_AW+1  entries currently queued
- req_sent_count  output  32  REQ blocks inserted, wraps modulo 2^32
- resp_sent_count  output  32  RESP blocks inserted, wraps modulo 2^32

## Operation
- Eligible slot: encoded_tx_hdr_in==2'b01, encoded_tx_data_in[7:0]==8'h1e, and encoded_tx_data_in[63:8]==0. Nothing else is eligible, including 0x1e blocks with non-zero C characters, ordered sets, start and terminate blocks, and data blocks.
- Slot decision, evaluated each cycle in priority order:
  - Eligible and response pending: output hdr 2'b01, data {resp_data_held, 8'h1f}. Clear pending; increment resp_sent_count.
  - Otherwise, eligible and FIFO non-empty: output hdr 2'b01, data {fifo_head, 8'h1a}. Pop the FIFO; increment req_sent_count.
  - Otherwise: output the input block unchanged.
- At most one insertion per slot. A response never displaces a request already in the FIFO; a request waits for the next eligible slot.
- Request FIFO:
  - Circular buffer with AW-bit read/write pointers that wrap from DEPTH-1 to 0.
  - Push when req_valid && req_ready.
  - req_ready = (level != DEPTH). It is computed from the registered level, so a same-cycle pop does not open space.
  - A simultaneous push and pop leaves the level unchanged.
  - The head is taken from registered storage, so an entry pushed in cycle N is eligible for insertion in cycle N+1 at the earliest.
- Response register:
  - resp_ready = !resp_pending.
  - Load resp_data when resp_valid && resp_ready, and set pending.
  - A new response cannot be loaded in the cycle its predecessor is inserted; the register reopens the next cycle.
- Counters increment by 1 and wrap from 0xFFFFFFFF to 0 with no saturation flag.

## Timing
- Latency is 1 cycle: the input block at edge N appears at the output after edge N+1, whether passed through or replaced. There are no bubbles, so the output cadence equals the input cadence.
- ipg_inserted is registered alongside the output block.
- Reset values, applied on the edge where rst=1:
  - encoded_tx_hdr_out=2'b01, encoded_tx_data_out=64'h1e (idle)
  - ipg_inserted=0, req_fifo_level=0
  - req_ready=1, resp_ready=1
  - both counters 0; pointers 0; pending 0
- Reset mid-operation flushes queued requests and any pending response without transmitting them. Handshakes presented while rst=1 are ignored.
- req_ready and resp_ready are pure functions of registered state, with no combinational path from inputs.

## Test plan
- Pass-through: 16 cycles of mixed data blocks (hdr 10) and 0x1e idle with FIFO empty → output equals input delayed 1 cycle; ipg_inserted stays 0; counters stay 0.
- Single request: push req_data=56'h00C0FFEE123456, then present an idle block → output is hdr 01, data 64'h00C0FFEE1234561a, one cycle after the idle; req_sent_count=1; level returns to 0.
- Priority: queue 2 requests and 1 response (resp_data=56'hABCDEF), then present 3 consecutive idles → output order is RESP (…ABCDEF1f), REQ0, REQ1; resp_ready rises the cycle after the RESP.
- Non-eligible blocks: queued request while the input carries 0x1e with non-zero C chars, a 0x78 start, and a 0x87 terminate → all pass unchanged; the request is held until a clean idle arrives.
- FIFO full / wrap: push 8 requests with no idles → req_ready=0, a 9th push is ignored; then 12 idles while pushing 4 more → 12 REQs out in push order; pointers wrap.
- Reset mid-queue: 3 requests and 1 pending response, assert rst for 1 cycle → next output is idle 64'h1e; level=0; both readies=1; subsequent idles pass through unchanged.

Source files
------------

// File: rtl/ipg_tx.sv
// ipg_tx: swaps clean all-idle control blocks for queued IPG request/response
// blocks on the way from the 64b/66b encoder to the TX gearbox.
// Every block, replaced or not, sees exactly one register stage of latency.
module ipg_tx #(
  parameter int unsigned REQ_FIFO_DEPTH = 8,
  parameter int unsigned REQ_FIFO_AW    = $clog2(REQ_FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [63:0]            encoded_tx_data_in,
  input  logic [1:0]             encoded_tx_hdr_in,
  input  logic [55:0]            req_data,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [55:0]            resp_data,
  input  logic                   resp_valid,
  output logic                   resp_ready,
  output logic [63:0]            encoded_tx_data_out,
  output logic [1:0]             encoded_tx_hdr_out,
  output logic                   ipg_inserted,
  output logic [REQ_FIFO_AW:0]   req_fifo_level,
  output logic [31:0]            req_sent_count,
  output logic [31:0]            resp_sent_count
);

  localparam int unsigned LW = REQ_FIFO_AW + 1;

  localparam logic [1:0] HDR_CTRL  = 2'b01;
  localparam logic [7:0] TYPE_IDLE = 8'h1e;
  localparam logic [7:0] TYPE_REQ  = 8'h1a;
  localparam logic [7:0] TYPE_RESP = 8'h1f;

  logic [55:0]            fifo_mem [REQ_FIFO_DEPTH];
  logic [REQ_FIFO_AW-1:0] wr_ptr;
  logic [REQ_FIFO_AW-1:0] rd_ptr;
  logic                   resp_pending;
  logic [55:0]            resp_held;

  logic        eligible_c;
  logic        fifo_empty_c;
  logic        ins_resp_c;
  logic        ins_req_c;
  logic        push_c;
  logic        resp_load_c;
  logic [63:0] data_nxt_c;
  logic [1:0]  hdr_nxt_c;

  // Handshake readies depend only on registered state.
  assign req_ready  = (req_fifo_level != LW'(REQ_FIFO_DEPTH));
  assign resp_ready = !resp_pending;

  // Slot qualification and insertion decision; response beats request.
  always_comb begin
    eligible_c   = (encoded_tx_hdr_in == HDR_CTRL) &&
                   (encoded_tx_data_in[7:0] == TYPE_IDLE) &&
                   (encoded_tx_data_in[63:8] == 56'd0);
    fifo_empty_c = (req_fifo_level == LW'(0));
    ins_resp_c   = eligible_c && resp_pending;
    ins_req_c    = eligible_c && !resp_pending && !fifo_empty_c;
    push_c       = req_valid && req_ready;
    resp_load_c  = resp_valid && resp_ready;
    data_nxt_c   = encoded_tx_data_in;
    hdr_nxt_c    = encoded_tx_hdr_in;
    if (ins_resp_c) begin
      data_nxt_c = {resp_held, TYPE_RESP};
      hdr_nxt_c  = HDR_CTRL;
    end else if (ins_req_c) begin
      data_nxt_c = {fifo_mem[rd_ptr], TYPE_REQ};
      hdr_nxt_c  = HDR_CTRL;
    end
  end

  // Request storage; contents need no reset since the level gates reads.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      fifo_mem[wr_ptr] <= req_data;
    end
  end

  // Output stage, FIFO bookkeeping, response register and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      encoded_tx_data_out <= 64'h1e;
      encoded_tx_hdr_out  <= HDR_CTRL;
      ipg_inserted        <= 1'b0;
      req_fifo_level      <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      resp_pending        <= 1'b0;
      resp_held           <= '0;
      req_sent_count      <= '0;
      resp_sent_count     <= '0;
    end else begin
      encoded_tx_data_out <= data_nxt_c;
      encoded_tx_hdr_out  <= hdr_nxt_c;
      ipg_inserted        <= ins_resp_c || ins_req_c;
      if (push_c) begin
        wr_ptr <= wr_ptr + REQ_FIFO_AW'(1);
      end
      if (ins_req_c) begin
        rd_ptr         <= rd_ptr + REQ_FIFO_AW'(1);
        req_sent_count <= req_sent_count + 32'd1;
      end
      if (push_c && !ins_req_c) begin
        req_fifo_level <= req_fifo_level + LW'(1);
      end else if (!push_c && ins_req_c) begin
        req_fifo_level <= req_fifo_level - LW'(1);
      end
      if (ins_resp_c) begin
        resp_pending    <= 1'b0;
        resp_sent_count <= resp_sent_count + 32'd1;
      end else if (resp_load_c) begin
        resp_pending <= 1'b1;
        resp_held    <= resp_data;
      end
    end
  end

endmodule

// File: tb/tb_ipg_tx.sv
// Directed bench for ipg_tx: each step drives one block, clocks once and
// checks the registered output against hand-computed values.
module tb_ipg_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] encoded_tx_data_in;
  logic [1:0]  encoded_tx_hdr_in;
  logic [55:0] req_data;
  logic        req_valid;
  logic        req_ready;
  logic [55:0] resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] encoded_tx_data_out;
  logic [1:0]  encoded_tx_hdr_out;
  logic        ipg_inserted;
  logic [3:0]  req_fifo_level;
  logic [31:0] req_sent_count;
  logic [31:0] resp_sent_count;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] IDLE = 64'h000000000000001e;

  ipg_tx dut (
    .clk                 (clk),
    .rst                 (rst),
    .encoded_tx_data_in  (encoded_tx_data_in),
    .encoded_tx_hdr_in   (encoded_tx_hdr_in),
    .req_data            (req_data),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .resp_data           (resp_data),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .encoded_tx_data_out (encoded_tx_data_out),
    .encoded_tx_hdr_out  (encoded_tx_hdr_out),
    .ipg_inserted        (ipg_inserted),
    .req_fifo_level      (req_fifo_level),
    .req_sent_count      (req_sent_count),
    .resp_sent_count     (resp_sent_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] hdr, input logic [63:0] data);
    encoded_tx_hdr_in  = hdr;
    encoded_tx_data_in = data;
  endtask

  // Output block and insertion flag after the most recent edge.
  task automatic chk_out(input string tag, input logic [1:0] hdr, input logic [63:0] data,
                         input logic ins);
    chk({tag, "_hdr"}, 64'(encoded_tx_hdr_out), 64'(hdr));
    chk({tag, "_data"}, encoded_tx_data_out, data);
    chk({tag, "_ins"}, 64'(ipg_inserted), 64'(ins));
  endtask

  initial begin
    logic [63:0] blk;
    rst = 1'b1;
    drive(2'b01, IDLE);
    req_data = '0; req_valid = 1'b0;
    resp_data = '0; resp_valid = 1'b0;

    // Reset state
    tick();
    rst = 1'b0;
    chk_out("rst", 2'b01, IDLE, 1'b0);
    chk("rst_level", 64'(req_fifo_level), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_ready", 64'(resp_ready), 64'd1);
    chk("rst_req_cnt", 64'(req_sent_count), 64'd0);
    chk("rst_resp_cnt", 64'(resp_sent_count), 64'd0);

    // Pass-through: mixed data and idle blocks with nothing queued
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        blk = 64'h0123456789abcdef ^ 64'(i * 32'h01010101);
        drive(2'b10, blk);
        tick();
        chk_out("pass_data", 2'b10, blk, 1'b0);
      end else begin
        drive(2'b01, IDLE);
        tick();
        chk_out("pass_idle", 2'b01, IDLE, 1'b0);
      end
    end
    chk("pass_req_cnt", 64'(req_sent_count), 64'd0);
    chk("pass_resp_cnt", 64'(resp_sent_count), 64'd0);

    // Single request: pushed alongside an idle, which must not carry it
    req_data = 56'h00C0FFEE123456; req_valid = 1'b1;
    drive(2'b01, IDLE);
    tick();
    req_valid = 1'b0;
    chk_out("push_same_idle", 2'b01, IDLE, 1'b0);
    chk("push_level", 64'(req_fifo_level), 64'd1);
    tick();
    chk_out("single_req", 2'b01, 64'h00C0FFEE1234561a, 1'b1);
    chk("single_cnt", 64'(req_sent_count), 64'd1);
    chk("single_level", 64'(req_fifo_level), 64'd0);

    // Priority: two requests then a response, drained by three idles
    drive(2'b10, 64'hAAAA_5555_AAAA_5555);
    req_data = 56'h11111111111111; req_valid = 1'b1;
    tick();
    req_data = 56'h22222222222222;
    resp_data = 56'hABCDEF; resp_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    resp_data = 56'h333333;
    chk("prio_level", 64'(req_fifo_level), 64'd2);
    chk("prio_resp_ready0", 64'(resp_ready), 64'd0);
    drive(2'b01, IDLE);
    tick();
    resp_valid = 1'b0;
    chk_out("prio_resp", 2'b01, 64'h00000000ABCDEF1f, 1'b1);
    chk("prio_resp_ready1", 64'(resp_ready), 64'd1);
    tick();
    chk_out("prio_req0", 2'b01, 64'h111111111111111a, 1'b1);
    tick();
    chk_out("prio_req1", 2'b01, 64'h222222222222221a, 1'b1);
    chk("prio_req_cnt", 64'(req_sent_count), 64'd3);
    chk("prio_resp_cnt", 64'(resp_sent_count), 64'd1);

    // Non-eligible blocks hold a queued request
    req_data = 56'h0000000000CCCC; req_valid = 1'b1;
    drive(2'b10, 64'h0);
    tick();
    req_valid = 1'b0;
    drive(2'b01, 64'h000000000000011e);
    tick();
    chk_out("ne_cchar", 2'b01, 64'h000000000000011e, 1'b0);
    drive(2'b01, 64'hD555555555555578);
    tick();
    chk_out("ne_start", 2'b01, 64'hD555555555555578, 1'b0);
    drive(2'b01, 64'h0000000000000087);
    tick();
    chk_out("ne_term", 2'b01, 64'h0000000000000087, 1'b0);
    drive(2'b10, IDLE);
    tick();
    chk_out("ne_datahdr", 2'b10, IDLE, 1'b0);
    chk("ne_level", 64'(req_fifo_level), 64'd1);
    drive(2'b01, IDLE);
    tick();
    chk_out("ne_release", 2'b01, 64'h0000000000CCCC1a, 1'b1);

    // FIFO full, ignored extra push, then drain with pointer wrap
    drive(2'b10, 64'hFEED_FACE_0000_0001);
    req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_data = 56'h5A0000 + 56'(k);
      tick();
    end
    chk("full_level", 64'(req_fifo_level), 64'd8);
    chk("full_ready", 64'(req_ready), 64'd0);
    req_data = 56'hDEAD;
    tick();
    chk("full_level_hold", 64'(req_fifo_level), 64'd8);
    drive(2'b01, IDLE);
    for (int j = 0; j < 12; j++) begin
      req_valid = (j >= 1 && j <= 4);
      req_data  = 56'h5A0000 + 56'(j + 7);
      if (j >= 1) chk("wrap_ready", 64'(req_ready), 64'd1);
      tick();
      chk_out("wrap_req", 2'b01, {56'h5A0000 + 56'(j), 8'h1a}, 1'b1);
    end
    req_valid = 1'b0;
    chk("wrap_level", 64'(req_fifo_level), 64'd0);
    chk("wrap_cnt", 64'(req_sent_count), 64'd16);

    // Reset mid-queue flushes requests and the pending response
    drive(2'b10, 64'h0BAD_0BAD_0BAD_0BAD);
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_data = 56'h7700 + 56'(k);
      resp_valid = (k == 0);
      resp_data = 56'h999999;
      tick();
    end
    resp_valid = 1'b0;
    chk("pre_rst_level", 64'(req_fifo_level), 64'd3);
    rst = 1'b1;
    resp_valid = 1'b1;
    drive(2'b01, IDLE);
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    resp_valid = 1'b0;
    chk_out("mrst", 2'b01, IDLE, 1'b0);
    chk("mrst_level", 64'(req_fifo_level), 64'd0);
    chk("mrst_req_ready", 64'(req_ready), 64'd1);
    chk("mrst_resp_ready", 64'(resp_ready), 64'd1);
    chk("mrst_req_cnt", 64'(req_sent_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("post_rst_idle", 2'b01, IDLE, 1'b0);
    end
    chk("post_rst_resp_cnt", 64'(resp_sent_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
